// File: rtl/rs_synd_seq.sv
// Serial Reed-Solomon syndrome sequencer over GF(2^4) (x^4+x+1), Horner-form update per accepted symbol.
// Optional feature: define RS_SYND_ERRFLAG_EN to add the registered err_o (non-zero syndrome) flag.
module rs_synd_seq #(
  parameter int N_SYM  = 15,
  parameter int N_SYND = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sym_valid_i,
  input  logic [3:0]            sym_i,
  output logic                  sym_ready_o,
  input  logic                  abort_i,
  output logic [4*N_SYND-1:0]   synd_o,
  output logic                  synd_valid_o,
  input  logic                  synd_ready_i,
  output logic [3:0]            sym_cnt_o
`ifdef RS_SYND_ERRFLAG_EN
  ,
  output logic                  err_o
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [3:0] LP_N_SYM = 4'(N_SYM);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [3:0]            r_cnt;
  logic [3:0]            w_cnt_nxt;
  logic [3:0]            w_cnt_inc;
  logic [4*N_SYND-1:0]   r_synd;
  logic [4*N_SYND-1:0]   w_synd_nxt;
  logic [4*N_SYND-1:0]   w_synd_upd;
  logic                  r_sym_ready;
  logic                  r_synd_valid;
  logic                  w_accept;

  // Multiply by alpha: shift left and fold x^4 back as x+1.
  function automatic logic [3:0] gf_mul_alpha(input logic [3:0] a);
    return {a[2:0], 1'b0} ^ {2'b00, a[3], a[3]};
  endfunction

  function automatic logic [3:0] gf_mul_alpha_pow(input logic [3:0] a, input int p);
    logic [3:0] v;
    v = a;
    for (int k = 0; k < 4; k++) begin
      if (k < p) begin
        v = gf_mul_alpha(v);
      end else begin
        v = v;
      end
    end
    return v;
  endfunction

  assign w_accept  = sym_valid_i && r_sym_ready;
  assign w_cnt_inc = r_cnt + 4'd1;

  // Horner step for every syndrome: S_j * alpha^j + symbol.
  always_comb begin
    w_synd_upd = '0;
    for (int j = 1; j <= N_SYND; j++) begin
      w_synd_upd[4*j-1 -: 4] = gf_mul_alpha_pow(r_synd[4*j-1 -: 4], j) ^ sym_i;
    end
  end

  // Next-state, counter and syndrome selection; abort overrides everything.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_synd_nxt  = r_synd;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = ST_ACC;
          w_cnt_nxt   = 4'd1;
          w_synd_nxt  = w_synd_upd;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ACC: begin
        if (w_accept) begin
          w_cnt_nxt  = w_cnt_inc;
          w_synd_nxt = w_synd_upd;
          if (w_cnt_inc == LP_N_SYM) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_state_nxt = ST_ACC;
          end
        end else begin
          w_state_nxt = ST_ACC;
        end
      end
      ST_DONE: begin
        if (synd_ready_i) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = 4'd0;
          w_synd_nxt  = '0;
        end else begin
          w_state_nxt = ST_DONE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = 4'd0;
        w_synd_nxt  = '0;
      end
    endcase
    if (abort_i) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = 4'd0;
      w_synd_nxt  = '0;
    end else begin
      w_state_nxt = w_state_nxt;
    end
  end

  // State and registered outputs, derived from the next state so they change with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= 4'd0;
      r_synd       <= '0;
      r_sym_ready  <= 1'b1;
      r_synd_valid <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_synd       <= w_synd_nxt;
      r_sym_ready  <= (w_state_nxt != ST_DONE);
      r_synd_valid <= (w_state_nxt == ST_DONE);
    end
  end

`ifdef RS_SYND_ERRFLAG_EN
  logic r_err;

  // Error flag registered with the syndromes; only meaningful while the set is presented.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else begin
      r_err <= (w_state_nxt == ST_DONE) ? (|w_synd_nxt) : 1'b0;
    end
  end

  assign err_o = r_err;
`endif

  assign sym_ready_o  = r_sym_ready;
  assign synd_valid_o = r_synd_valid;
  assign synd_o       = r_synd;
  assign sym_cnt_o    = r_cnt;

endmodule

// File: tb/tb_rs_synd_seq.sv
// Scoreboard bench for rs_synd_seq: directed lpGBT cases plus randomized codewords against
// a polynomial-evaluation syndrome model built from GF(2^4) log/antilog tables.
module tb_rs_synd_seq;

  localparam int N_SYM  = 15;
  localparam int N_SYND = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        sym_valid_i;
  logic [3:0]  sym_i;
  logic        sym_ready_o;
  logic        abort_i;
  logic [15:0] synd_o;
  logic        synd_valid_o;
  logic        synd_ready_i;
  logic [3:0]  sym_cnt_o;
`ifdef RS_SYND_ERRFLAG_EN
  logic        err_o;
`endif

  rs_synd_seq #(.N_SYM(N_SYM), .N_SYND(N_SYND)) dut (
    .clk          (clk),
    .rst          (rst),
    .sym_valid_i  (sym_valid_i),
    .sym_i        (sym_i),
    .sym_ready_o  (sym_ready_o),
    .abort_i      (abort_i),
    .synd_o       (synd_o),
    .synd_valid_o (synd_valid_o),
    .synd_ready_i (synd_ready_i),
    .sym_cnt_o    (sym_cnt_o)
`ifdef RS_SYND_ERRFLAG_EN
    ,
    .err_o        (err_o)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int gexp [15];
  int glog [16];
  logic [3:0]  cw [N_SYM];
  logic [15:0] exp_q [$];
  int m_cnt   = 0;
  bit m_done  = 0;
  int n_push  = 0;
  int n_pop   = 0;
  int n_drop  = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic int gmul(input int a, input int b);
    if (a == 0 || b == 0) return 0;
    return gexp[(glog[a] + glog[b]) % 15];
  endfunction

  // Syndrome S_j = r(alpha^j), first symbol is the x^(N_SYM-1) coefficient.
  function automatic logic [15:0] ref_synd();
    logic [15:0] res;
    res = 16'h0000;
    for (int j = 1; j <= N_SYND; j++) begin
      int acc;
      acc = 0;
      for (int k = 0; k < N_SYM; k++) begin
        acc = acc ^ gmul(int'(cw[k]), gexp[(j * (N_SYM - 1 - k)) % 15]);
      end
      res[4*j-1 -: 4] = 4'(acc);
    end
    return res;
  endfunction

  // One cycle of stimulus: check outputs settled from the last edge, drive, advance the model.
  task automatic step(input logic v, input logic [3:0] s, input logic r, input logic a,
                      input logic dchk, input logic [15:0] dval);
    @(posedge clk); #1;
    check("sym_ready", {15'd0, sym_ready_o}, {15'd0, !m_done});
    check("synd_valid", {15'd0, synd_valid_o}, {15'd0, m_done});
    check("sym_cnt", {12'd0, sym_cnt_o}, 16'(m_cnt));
    if (m_done && exp_q.size() > 0) check("synd_hold", synd_o, exp_q[0]);
    if (!m_done && m_cnt == 0) check("synd_clear", synd_o, 16'h0000);
    if (dchk) begin
      check("synd_directed", synd_o, dval);
`ifdef RS_SYND_ERRFLAG_EN
      check("err_directed", {15'd0, err_o}, {15'd0, dval != 16'h0000});
`endif
    end
    sym_valid_i  = v;
    sym_i        = s;
    synd_ready_i = r;
    abort_i      = a;
    if (a) begin
      if (m_done) begin
        exp_q.delete(0);
        n_drop++;
      end
      m_done = 0;
      m_cnt  = 0;
    end else if (m_done) begin
      if (r) begin
        m_done = 0;
        m_cnt  = 0;
      end
    end else if (v) begin
      cw[m_cnt] = s;
      m_cnt++;
      if (m_cnt == N_SYM) begin
        m_done = 1;
        exp_q.push_back(ref_synd());
        n_push++;
      end
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    rst = 1'b1; sym_valid_i = 1'b0; synd_ready_i = 1'b0; abort_i = 1'b0;
    @(posedge clk); #1;
    check("rst_ready", {15'd0, sym_ready_o}, 16'h0001);
    check("rst_valid", {15'd0, synd_valid_o}, 16'h0000);
    check("rst_synd", synd_o, 16'h0000);
    check("rst_cnt", {12'd0, sym_cnt_o}, 16'h0000);
`ifdef RS_SYND_ERRFLAG_EN
    check("rst_err", {15'd0, err_o}, 16'h0000);
`endif
    rst    = 1'b0;
    m_cnt  = 0;
    m_done = 0;
  endtask

  // Scoreboard monitor: a set leaves the DUT on every valid/ready handshake not overridden.
  always @(negedge clk) begin
    if (!rst && !abort_i && synd_valid_o && synd_ready_i) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_dup: got unexpected set %h, expected none", synd_o);
      end else begin
        check("sb_synd", synd_o, exp_q[0]);
`ifdef RS_SYND_ERRFLAG_EN
        check("sb_err", {15'd0, err_o}, {15'd0, exp_q[0] != 16'h0000});
`endif
        exp_q.delete(0);
        n_pop++;
      end
    end
  end

  initial begin
    int x;
    int cyc;
    x = 1;
    glog[0] = 0;
    for (int i = 0; i < 15; i++) begin
      gexp[i] = x;
      glog[x] = i;
      x = x << 1;
      if ((x & 16) != 0) x = x ^ 19;
    end

    rst = 1'b1; sym_valid_i = 1'b0; sym_i = 4'h0; synd_ready_i = 1'b0; abort_i = 1'b0;
    pulse_reset();

    // 1: all-zero codeword back-to-back
    for (int i = 0; i < N_SYM; i++) step(1'b1, 4'h0, 1'b1, 1'b0, 1'b0, 16'h0);
    step(1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 16'h0000);

    // 2: single 1 at x^14
    step(1'b1, 4'h1, 1'b1, 1'b0, 1'b0, 16'h0);
    for (int i = 1; i < N_SYM; i++) step(1'b1, 4'h0, 1'b1, 1'b0, 1'b0, 16'h0);
    step(1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 16'hEFD9);

    // 3: single 1 at x^0, then held while downstream stalls and symbols are offered
    for (int i = 1; i < N_SYM; i++) step(1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 16'h0);
    step(1'b1, 4'h1, 1'b0, 1'b0, 1'b0, 16'h0);
    for (int i = 0; i < 5; i++) step(1'b1, 4'($urandom_range(0, 15)), 1'b0, 1'b0, 1'b1, 16'h1111);
    step(1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 16'h1111);

    // 4: abort after 7 symbols (symbol in the abort cycle discarded), then test-2 codeword
    for (int i = 0; i < 7; i++) step(1'b1, 4'($urandom_range(1, 15)), 1'b1, 1'b0, 1'b0, 16'h0);
    step(1'b1, 4'h7, 1'b1, 1'b1, 1'b0, 16'h0);
    step(1'b1, 4'h1, 1'b1, 1'b0, 1'b0, 16'h0);
    for (int i = 1; i < N_SYM; i++) step(1'b1, 4'h0, 1'b1, 1'b0, 1'b0, 16'h0);
    step(1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 16'hEFD9);

    // 5: reset after 10 symbols, then a random codeword
    for (int i = 0; i < 10; i++) step(1'b1, 4'($urandom_range(0, 15)), 1'b1, 1'b0, 1'b0, 16'h0);
    pulse_reset();
    for (int i = 0; i < N_SYM; i++) step(1'b1, 4'($urandom_range(0, 15)), 1'b1, 1'b0, 1'b0, 16'h0);
    step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 16'h0);

    // 6: random gaps on both sides, rare aborts
    cyc = 0;
    while (n_push < 1005 && cyc < 60000) begin
      step(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 399) == 0), 1'b0, 16'h0);
      cyc++;
    end
    if (cyc >= 60000) check("random_budget", 16'(n_push), 16'd1005);

    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() != 0 || m_cnt != 0 || m_done) step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 16'h0);
    end
    @(posedge clk); #1;
    check("lost_sets", 16'(exp_q.size()), 16'd0);
    check("set_count", 16'(n_pop + n_drop), 16'(n_push));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
